// File: rtl/mem_panel_ctrl.sv
// Front-panel controller for a single-port synchronous RAM: debounced one-shot
// buttons drive address/write commands, and the word at the address is latched for display.
module mem_panel_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int DISP_W     = 12,
    parameter int DEBOUNCE_N = 16,
    parameter int RD_LAT     = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [3:0]        btn_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [DISP_W-1:0] disp_o,
    output logic              busy_o
);

    // state   | meaning
    // IDLE    | waiting for a press pulse
    // WRITE   | one-cycle write strobe at the current address
    // RD_WAIT | waiting RD_LAT cycles for read data
    // CAPTURE | latch read data into the display register
    typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, CAPTURE} state_t;

    localparam int DB_W  = $clog2(DEBOUNCE_N);
    localparam int WC_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int CAP_W = (DATA_W < DISP_W) ? DATA_W : DISP_W;

    localparam int BTN_INC  = 0;
    localparam int BTN_HOME = 1;
    localparam int BTN_WR   = 2;
    localparam int BTN_DEC  = 3;

    logic [3:0]            sync1_q, sync2_q, level_q, press_q;
    logic [3:0][DB_W-1:0]  dbcnt_q;

    state_t                state_q;
    logic [WC_W-1:0]       wcnt_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  we_q;
    logic [DATA_W-1:0]     wdat_q;
    logic [DISP_W-1:0]     disp_q, disp_d;
    logic                  busy_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            dbcnt_q <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                press_q[i] <= 1'b0;
                // Level must disagree for DEBOUNCE_N consecutive cycles; any agreement restarts.
                if (sync2_q[i] != level_q[i]) begin
                    if (dbcnt_q[i] == DB_W'(DEBOUNCE_N - 1)) begin
                        level_q[i] <= sync2_q[i];
                        press_q[i] <= sync2_q[i];
                        dbcnt_q[i] <= '0;
                    end else begin
                        dbcnt_q[i] <= dbcnt_q[i] + DB_W'(1);
                    end
                end else begin
                    dbcnt_q[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        disp_d = DISP_W'(mem_data_i[CAP_W-1:0]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RD_WAIT;
            wcnt_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            disp_q  <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    wcnt_q <= '0;
                    if (press_q[BTN_HOME]) begin
                        addr_q  <= '0;
                        state_q <= RD_WAIT;
                        busy_q  <= 1'b1;
                    end else if (press_q[BTN_INC]) begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        state_q <= RD_WAIT;
                        busy_q  <= 1'b1;
                    end else if (press_q[BTN_DEC]) begin
                        addr_q  <= addr_q - ADDR_W'(1);
                        state_q <= RD_WAIT;
                        busy_q  <= 1'b1;
                    end else if (press_q[BTN_WR]) begin
                        wdat_q  <= wdata_i;
                        we_q    <= 1'b1;
                        state_q <= WRITE;
                        busy_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    we_q    <= 1'b0;
                    wcnt_q  <= '0;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (wcnt_q == WC_W'(RD_LAT - 1)) begin
                        wcnt_q  <= '0;
                        state_q <= CAPTURE;
                    end else begin
                        wcnt_q <= wcnt_q + WC_W'(1);
                    end
                end
                CAPTURE: begin
                    disp_q  <= disp_d;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr_o = addr_q;
    assign mem_we_o   = we_q;
    assign mem_data_o = wdat_q;
    assign disp_o     = disp_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_mem_panel_ctrl.sv
// Bench for mem_panel_ctrl: directed button sequences, expected read-backs and
// writes queued at stimulus time and popped by a monitor when the DUT completes.
module tb_mem_panel_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int PW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    btn = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [PW-1:0] disp;
    logic          busy;

    mem_panel_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .DISP_W(PW), .DEBOUNCE_N(4), .RD_LAT(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .btn_i(btn), .wdata_i(wdata),
        .mem_data_i(mem_rdata), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
        .mem_data_o(mem_wdata), .disp_o(disp), .busy_o(busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [16];
    initial for (int a = 0; a < 16; a++) ram[a] = 8'(a) + 8'h10;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct { logic [AW-1:0] addr; logic [PW-1:0] disp; } rd_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    rd_t rd_q[$];
    wr_t wr_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic exp_rd(input logic [AW-1:0] a, input logic [PW-1:0] d);
        rd_q.push_back('{a, d});
    endtask

    task automatic tap(input int b, input int hold);
        btn[b] = 1'b1;
        repeat (hold) @(negedge clk);
        btn[b] = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    logic busy_prev = 1'b0;
    always @(negedge clk) begin : monitor
        rd_t r;
        wr_t w;
        if (!rst) begin
            if (busy_prev && !busy) begin
                if (rd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_read: addr %0h disp %0h, none expected", mem_addr, disp);
                end else begin
                    r = rd_q.pop_front();
                    check("rd_addr", 32'(mem_addr), 32'(r.addr));
                    check("rd_disp", 32'(disp), 32'(r.disp));
                end
            end
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_wdata);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(w.addr));
                    check("wr_data", 32'(mem_wdata), 32'(w.data));
                end
            end
        end
        busy_prev = busy;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit found;

        // reset values and the automatic read of address 0
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_wdata", 32'(mem_wdata), 32'h0);
        check("rst_disp", 32'(disp), 32'h0);
        check("rst_busy", 32'(busy), 32'h1);
        exp_rd(4'h0, 12'h010);
        rst = 1'b0;
        n = 0;
        while (busy && n < 3) begin
            @(negedge clk);
            n++;
        end
        check("busy_fall", 32'(busy), 32'h0);
        repeat (4) @(negedge clk);

        // increment latency and held button
        exp_rd(4'h1, 12'h011);
        btn[0] = 1'b1;
        repeat (6) @(negedge clk);
        check("inc_before7", 32'(mem_addr), 32'h0);
        @(negedge clk);
        check("inc_at7", 32'(mem_addr), 32'h1);
        repeat (20) @(negedge clk);
        btn[0] = 1'b0;
        repeat (12) @(negedge clk);
        check("held_single", 32'(mem_addr), 32'h1);

        // home, dec wrap at 0, inc wrap at max
        exp_rd(4'h0, 12'h010);
        tap(1, 10);
        exp_rd(4'hF, 12'h01F);
        tap(3, 10);
        check("dec_wrap", 32'(mem_addr), 32'hF);
        exp_rd(4'h0, 12'h010);
        tap(0, 10);
        check("inc_wrap", 32'(mem_addr), 32'h0);

        // walk to 5 then write A7
        exp_rd(4'h1, 12'h011); tap(0, 10);
        exp_rd(4'h2, 12'h012); tap(0, 10);
        exp_rd(4'h3, 12'h013); tap(0, 10);
        exp_rd(4'h4, 12'h014); tap(0, 10);
        exp_rd(4'h5, 12'h015); tap(0, 10);
        wdata = 8'hA7;
        wr_q.push_back('{4'h5, 8'hA7});
        exp_rd(4'h5, 12'h0A7);
        tap(2, 10);
        wdata = 8'h00;

        // bounce shorter than the debounce window, then a clean press
        for (int i = 0; i < 10; i++) begin
            btn[0] = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check("bounce_no_inc", 32'(mem_addr), 32'h5);
        exp_rd(4'h6, 12'h016);
        tap(0, 15);

        // back to 3, then home and inc together
        exp_rd(4'h5, 12'h0A7); tap(3, 10);
        exp_rd(4'h4, 12'h014); tap(3, 10);
        exp_rd(4'h3, 12'h013); tap(3, 10);
        check("at_3", 32'(mem_addr), 32'h3);
        exp_rd(4'h0, 12'h010);
        btn[1] = 1'b1;
        btn[0] = 1'b1;
        repeat (10) @(negedge clk);
        btn = '0;
        repeat (12) @(negedge clk);
        check("home_wins", 32'(mem_addr), 32'h0);

        // dec pulse lands one cycle after inc, while busy
        exp_rd(4'h1, 12'h011);
        btn[0] = 1'b1;
        @(negedge clk);
        btn[3] = 1'b1;
        repeat (10) @(negedge clk);
        btn = '0;
        repeat (12) @(negedge clk);
        check("busy_drop", 32'(mem_addr), 32'h1);

        // reset in the middle of a write
        wdata = 8'h5C;
        btn[2] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1;
            if (mem_we) found = 1'b1;
        end
        check("we_seen", 32'(found), 32'h1);
        rst = 1'b1;
        #1;
        check("rstw_we", 32'(mem_we), 32'h0);
        check("rstw_addr", 32'(mem_addr), 32'h0);
        check("rstw_wdata", 32'(mem_wdata), 32'h0);
        check("rstw_disp", 32'(disp), 32'h0);
        check("rstw_busy", 32'(busy), 32'h1);
        btn[2] = 1'b0;
        repeat (3) @(negedge clk);
        exp_rd(4'h0, 12'h010);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        check("rd_q_empty", 32'(rd_q.size()), 32'h0);
        check("wr_q_empty", 32'(wr_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
